// File: rtl/bsg_manycore_ep_req_arbiter.sv
// Round-robin arbiter and credit gate feeding a one-entry endpoint request stage.
// Define BSG_MANYCORE_EP_ARB_LOCK_EN to let a requester keep the grant across packets.
module bsg_manycore_ep_req_arbiter #(
    parameter int num_req_p              = 4,
    parameter int fifo_width_p           = 128,
    parameter int credit_counter_width_p = 6,
    parameter int credit_reserve_p       = 0,
    parameter int id_width_lp            = (num_req_p > 1) ? $clog2(num_req_p) : 1
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [num_req_p-1:0]              req_v_i,
    input  logic [num_req_p*fifo_width_p-1:0] req_data_i,
    input  logic [num_req_p-1:0]              req_lock_i,
    output logic [num_req_p-1:0]              req_ready_o,
    input  logic [credit_counter_width_p-1:0] out_credits_i,
    output logic                              endpoint_req_v_o,
    output logic [fifo_width_p-1:0]           endpoint_req_data_o,
    input  logic                              endpoint_req_ready_i,
    output logic [id_width_lp-1:0]            grant_id_o,
    output logic                              stall_credit_o
);
    localparam int pend_width_lp = credit_counter_width_p + 2;

    logic                     v_r;
    logic                     acc_r;
    logic [fifo_width_p-1:0]  data_r;
    logic [id_width_lp-1:0]   id_r;
    logic [id_width_lp-1:0]   last_r;

    logic                     drain;
    logic                     slot_free;
    logic                     credit_ok;
    logic                     issue;
    logic                     found;
    logic [pend_width_lp-1:0] pending;
    logic [num_req_p-1:0]     eligible_v;
    logic [id_width_lp-1:0]   winner;

    assign drain     = v_r & endpoint_req_ready_i;
    assign slot_free = ~v_r | drain;

    // Credits already spent but possibly not yet reflected in out_credits_i.
    assign pending   = pend_width_lp'(v_r & ~drain) + pend_width_lp'(acc_r);
    assign credit_ok = pend_width_lp'(out_credits_i) > (pend_width_lp'(credit_reserve_p) + pending);

`ifdef BSG_MANYCORE_EP_ARB_LOCK_EN
    typedef enum logic {IDLE, LOCKED} lock_state_e;

    lock_state_e            state_r, state_n;
    logic [id_width_lp-1:0] lock_id_r, lock_id_n;

    always_comb begin
        eligible_v = req_v_i;
        if (state_r == LOCKED) begin
            eligible_v            = '0;
            eligible_v[lock_id_r] = req_v_i[lock_id_r];
        end
    end

    always_comb begin
        state_n   = state_r;
        lock_id_n = lock_id_r;
        case (state_r)
            IDLE: begin
                if (issue && req_lock_i[winner]) begin
                    state_n   = LOCKED;
                    lock_id_n = winner;
                end
            end
            LOCKED: begin
                if (issue && !req_lock_i[lock_id_r]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_r   <= IDLE;
            lock_id_r <= '0;
        end else begin
            state_r   <= state_n;
            lock_id_r <= lock_id_n;
        end
    end
`else
    logic unused_lock;
    assign unused_lock = ^req_lock_i;
    assign eligible_v  = req_v_i;
`endif

    // Scan from last_r+1 upward so the previous winner is considered last.
    // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
    always_comb begin
        int idx;
        winner = last_r;
        found  = 1'b0;
        idx    = 0;
        for (int i = 1; i <= num_req_p; i++) begin
            idx = int'(last_r) + i;
            if (idx >= num_req_p) idx = idx - num_req_p;
            if (!found && eligible_v[idx]) begin
                found  = 1'b1;
                winner = id_width_lp'(idx);
            end
        end
    end

    assign issue = slot_free & credit_ok & found;

    always_comb begin
        req_ready_o = '0;
        if (issue && !reset_i) req_ready_o[winner] = 1'b1;
    end

    assign stall_credit_o = ~reset_i & slot_free & found & ~credit_ok;

    // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            v_r    <= 1'b0;
            acc_r  <= 1'b0;
            data_r <= '0;
            id_r   <= '0;
            last_r <= id_width_lp'(num_req_p - 1);
        end else begin
            acc_r <= drain;
            if (issue) begin
                v_r    <= 1'b1;
                data_r <= req_data_i[int'(winner)*fifo_width_p +: fifo_width_p];
                id_r   <= winner;
                last_r <= winner;
            end else if (drain) begin
                v_r <= 1'b0;
            end
        end
    end

    assign endpoint_req_v_o    = v_r;
    assign endpoint_req_data_o = data_r;
    assign grant_id_o          = id_r;

endmodule

// File: tb/tb_bsg_manycore_ep_req_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
// Two instances run side by side: credit reserve 0 and credit reserve 3.
`timescale 1ns/1ps
module tb_bsg_manycore_ep_req_arbiter;
    localparam int N  = 4;
    localparam int FW = 128;
    localparam int CW = 6;

    logic            clk     = 1'b0;
    logic            reset_i = 1'b1;
    logic [N-1:0]    req_v       [2];
    logic [N*FW-1:0] req_data    [2];
    logic [N-1:0]    req_lock    [2];
    logic [N-1:0]    req_ready   [2];
    logic [CW-1:0]   out_credits [2];
    logic            ep_v        [2];
    logic [FW-1:0]   ep_data     [2];
    logic            ep_ready    [2];
    logic [1:0]      grant_id    [2];
    logic            stall       [2];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bsg_manycore_ep_req_arbiter #(
        .num_req_p(N), .fifo_width_p(FW), .credit_counter_width_p(CW), .credit_reserve_p(0)
    ) u_dut0 (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v[0]), .req_data_i(req_data[0]), .req_lock_i(req_lock[0]),
        .req_ready_o(req_ready[0]), .out_credits_i(out_credits[0]),
        .endpoint_req_v_o(ep_v[0]), .endpoint_req_data_o(ep_data[0]),
        .endpoint_req_ready_i(ep_ready[0]), .grant_id_o(grant_id[0]),
        .stall_credit_o(stall[0])
    );

    bsg_manycore_ep_req_arbiter #(
        .num_req_p(N), .fifo_width_p(FW), .credit_counter_width_p(CW), .credit_reserve_p(3)
    ) u_dut1 (
        .clk_i(clk), .reset_i(reset_i),
        .req_v_i(req_v[1]), .req_data_i(req_data[1]), .req_lock_i(req_lock[1]),
        .req_ready_o(req_ready[1]), .out_credits_i(out_credits[1]),
        .endpoint_req_v_o(ep_v[1]), .endpoint_req_data_o(ep_data[1]),
        .endpoint_req_ready_i(ep_ready[1]), .grant_id_o(grant_id[1]),
        .stall_credit_o(stall[1])
    );

    // Behavioural view of each instance plus the endpoint's credit counter.
    typedef struct {
        bit          v;
        logic [FW-1:0] data;
        int          id;
        bit          acc;
        int          last;
        bit          locked;
        int          lock_id;
        int          credits;
        bit          auto_dec;
    } model_t;

    model_t m         [2];
    int     last_w    [2];
    bit     obs_issue [2];

    function automatic int rsv(int k);
        return (k == 0) ? 0 : 3;
    endfunction

    task automatic check(string tag, logic [127:0] obs, logic [127:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic model_reset(int k);
        m[k].v       = 1'b0;
        m[k].data    = '0;
        m[k].id      = 0;
        m[k].acc     = 1'b0;
        m[k].last    = N - 1;
        m[k].locked  = 1'b0;
        m[k].lock_id = 0;
    endtask

    task automatic new_data(int k);
        for (int j = 0; j < N*FW/32; j++) req_data[k][j*32 +: 32] = $urandom;
    endtask

    task automatic drive();
        for (int k = 0; k < 2; k++) out_credits[k] = CW'(m[k].credits);
    endtask

    // First valid requester after the last winner, honouring an active lock.
    function automatic int pick(int k);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (m[k].last + i) % N;
            if (req_v[k][c] && (!m[k].locked || c == m[k].lock_id)) return c;
        end
        return -1;
    endfunction

    // One clock cycle: check combinational outputs, clock, advance model, check registered outputs.
    task automatic step(string tag);
        int           w  [2];
        bit           st [2];
        bit           dr [2];
        bit           ok;
        bit           free;
        int           pend;
        logic [N-1:0] exp_rdy;
        drive();
        #1;
        for (int k = 0; k < 2; k++) begin
            free  = !m[k].v || ep_ready[k];
            pend  = ((m[k].v && !ep_ready[k]) ? 1 : 0) + (m[k].acc ? 1 : 0);
            ok    = m[k].credits > rsv(k) + pend;
            w[k]  = pick(k);
            st[k] = free && (w[k] >= 0) && !ok;
            if (!(free && ok)) w[k] = -1;
            exp_rdy = (w[k] >= 0) ? N'(1 << w[k]) : '0;
            check($sformatf("%s/%0d rdy", tag, k), req_ready[k], exp_rdy);
            check($sformatf("%s/%0d stall", tag, k), stall[k], st[k]);
            obs_issue[k] = |req_ready[k];
            dr[k] = m[k].v && ep_ready[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            m[k].acc  = dr[k];
            last_w[k] = w[k];
            if (w[k] >= 0) begin
`ifdef BSG_MANYCORE_EP_ARB_LOCK_EN
                if (!m[k].locked && req_lock[k][w[k]]) begin
                    m[k].locked  = 1'b1;
                    m[k].lock_id = w[k];
                end else if (m[k].locked && !req_lock[k][w[k]]) begin
                    m[k].locked = 1'b0;
                end
`endif
                m[k].v    = 1'b1;
                m[k].data = req_data[k][w[k]*FW +: FW];
                m[k].id   = w[k];
                m[k].last = w[k];
            end else if (dr[k]) begin
                m[k].v = 1'b0;
            end
            if (m[k].auto_dec && dr[k] && m[k].credits > 0) m[k].credits--;
        end
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("%s/%0d v", tag, k), ep_v[k], m[k].v);
            check($sformatf("%s/%0d data", tag, k), ep_data[k], m[k].data);
            check($sformatf("%s/%0d id", tag, k), grant_id[k], m[k].id);
        end
    endtask

    task automatic idle(int cycles);
        for (int k = 0; k < 2; k++) begin
            req_v[k]    = '0;
            req_lock[k] = '0;
            ep_ready[k] = 1'b1;
        end
        for (int i = 0; i < cycles; i++) step("idle");
    endtask

    initial begin
        int            rr_seq [5];
        int            lk_seq [5];
        int            cnt;
        int            c1;
        logic [FW-1:0] held;

        rr_seq = '{0, 1, 2, 3, 0};
`ifdef BSG_MANYCORE_EP_ARB_LOCK_EN
        lk_seq = '{1, 1, 1, 3, 0};
`else
        lk_seq = '{1, 3, 0, 1, 3};
`endif
        for (int k = 0; k < 2; k++) begin
            req_v[k]      = (k == 0) ? '1 : '0;
            req_lock[k]   = '0;
            ep_ready[k]   = 1'b1;
            m[k].credits  = 32;
            m[k].auto_dec = 1'b0;
            new_data(k);
            model_reset(k);
        end

        // Reset state, with requests already pending.
        reset_i = 1'b1;
        drive();
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("rst/%0d v", k), ep_v[k], 1'b0);
            check($sformatf("rst/%0d rdy", k), req_ready[k], '0);
            check($sformatf("rst/%0d stall", k), stall[k], 1'b0);
            check($sformatf("rst/%0d id", k), grant_id[k], 0);
            check($sformatf("rst/%0d data", k), ep_data[k], '0);
        end
        #3 reset_i = 1'b0;

        // Round-robin from reset: 0,1,2,3,0 with output valid one cycle after the first grant.
        #1;
        check("rr_first_rdy", req_ready[0], 4'b0001);
        for (int i = 0; i < 5; i++) begin
            new_data(0);
            step("rr");
            check($sformatf("rr_grant%0d", i), grant_id[0], rr_seq[i]);
            if (i == 0) check("rr_v_first", ep_v[0], 1'b1);
        end

        // Backpressure: one issue, stage held, then drain and reissue on the same edge.
        idle(2);
        req_v[0]    = 4'b0100;
        ep_ready[0] = 1'b0;
        new_data(0);
        step("bp_issue");
        held = req_data[0][2*FW +: FW];
        for (int i = 0; i < 4; i++) begin
            new_data(0);
            #1;
            check("bp_rdy_low", req_ready[0], '0);
            step("bp_hold");
            check("bp_data_held", ep_data[0], held);
        end
        ep_ready[0] = 1'b1;
        new_data(0);
        #1;
        check("bp_reissue_rdy", req_ready[0], 4'b0100);
        step("bp_release");
        check("bp_new_data", ep_data[0], req_data[0][2*FW +: FW]);
        check("bp_new_v", ep_v[0], 1'b1);

        // Credit exhaustion with the endpoint consuming credits on every accept.
        idle(3);
        m[0].credits  = 2;
        m[0].auto_dec = 1'b1;
        req_v[0]      = '1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            new_data(0);
            step("cx");
            if (obs_issue[0]) cnt++;
        end
        check("cx_issue_count", cnt, 2);
        #1;
        check("cx_stall", stall[0], 1'b1);

        // One credit returned while the endpoint holds off: exactly one more issue.
        m[0].credits = 1;
        ep_ready[0]  = 1'b0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            new_data(0);
            step("cr");
            if (obs_issue[0]) cnt++;
        end
        check("cr_issue_count", cnt, 1);
        idle(3);
        m[0].credits  = 32;
        m[0].auto_dec = 1'b0;

        // Reserve of 3: credits=3 blocks, credits=4 issues.
        req_v[1]     = '1;
        m[1].credits = 3;
        drive();
        #1;
        check("rsv3_rdy", req_ready[1], '0);
        check("rsv3_stall", stall[1], 1'b1);
        step("rsv3");
        m[1].credits = 4;
        drive();
        #1;
        check("rsv4_rdy", req_ready[1], 4'b0001);
        check("rsv4_stall", stall[1], 1'b0);
        step("rsv4");
        m[1].auto_dec = 1'b1;
        for (int i = 0; i < 4; i++) begin
            new_data(1);
            step("rsv_run");
        end
        check("rsv_end_stall", stall[1], 1'b1);
        m[1].auto_dec = 1'b0;
        m[1].credits  = 32;
        idle(2);

        // Lock scenario: requester 1 sends three packets (lock 1,1,0) against 0 and 3.
        req_v[0] = 4'b0001;
        step("lk_pre");
        req_v[0]    = 4'b1011;
        req_lock[0] = 4'b0010;
        c1 = 0;
        for (int i = 0; i < 5; i++) begin
            new_data(0);
            step("lk");
            check($sformatf("lk_grant%0d", i), grant_id[0], lk_seq[i]);
            if (last_w[0] == 1) begin
                c1++;
                if (c1 == 2) req_lock[0][1] = 1'b0;
                if (c1 == 3) req_v[0][1] = 1'b0;
            end
        end
        idle(2);

        // Random traffic on both instances.
        for (int i = 0; i < 300; i++) begin
            for (int k = 0; k < 2; k++) begin
                req_v[k]     = N'($urandom);
                req_lock[k]  = N'($urandom);
                ep_ready[k]  = ($urandom_range(0, 3) != 0);
                m[k].credits = $urandom_range(0, 7);
                new_data(k);
            end
            step("rnd");
        end

        // Asynchronous reset in the middle of a burst.
        for (int k = 0; k < 2; k++) begin
            req_v[k]     = '1;
            req_lock[k]  = '0;
            ep_ready[k]  = 1'b1;
            m[k].credits = 32;
        end
        step("ar_pre");
        step("ar_pre");
        #2 reset_i = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ar/%0d v", k), ep_v[k], 1'b0);
            check($sformatf("ar/%0d rdy", k), req_ready[k], '0);
            check($sformatf("ar/%0d stall", k), stall[k], 1'b0);
            model_reset(k);
        end
        @(posedge clk);
        #4 reset_i = 1'b0;
        step("ar_post");
        check("ar_first_grant", grant_id[0], 0);
        check("ar_first_v", ep_v[0], 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
